uart_rx_os: RTL and testbench
=============================

# uart_rx_os

16x-oversampling UART receiver with an on-chip receive FIFO, used as the SoC-side input of the serial link: the board's USB-UART transmit pin is routed (raw, asynchronous) into `rx_i`, and the CPU/bus side drains received bytes through a valid/ready interface. It synchronises the line, qualifies start bits, majority-votes each bit, checks stop (and optional parity), and buffers bytes so that software polling jitter does not lose characters.

## Interface
- `BAUD_DIV`, 27 — clocks per oversample tick; bit period = 16*BAUD_DIV clocks (27 -> ~115200 baud at 50 MHz); legal range 2..65535
- `FIFO_DEPTH`, 8 — receive FIFO entries; power of two, 2..64
- `PARITY_ODD`, 0 — 1 = odd parity, 0 = even; used only when parity is compiled in

Ports:
- `clk_i` in 1 — single system clock
- `arst_n_i` in 1 — asynchronous, active-low reset
- `rx_i` in 1 — raw serial line, idle high, asynchronous to `clk_i`
- `rdata_o` out 8 — FIFO head byte (first-word-fall-through)
- `rvalid_o` out 1 — FIFO non-empty
- `rready_i` in 1 — consumer accepts `rdata_o` when `rvalid_o & rready_i`
- `frame_err_o` out 1 — 1-cycle pulse: stop bit sampled low
- `parity_err_o` out 1 — 1-cycle pulse: parity mismatch
- `overrun_o` out 1 — 1-cycle pulse: byte dropped, FIFO full
- `busy_o` out 1 — receiver FSM not in IDLE

## Operation
- `rx_i` passes a 2-FF synchroniser (reset value 1); all logic uses the synchronised signal.
- Tick counter counts 0..BAUD_DIV-1 and runs continuously; sample counter 0..15 counts ticks within a bit, restarted on start detection.
- States: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE: on synchronised 1->0 transition go to START, clear tick and sample counters.
- Each bit is sampled at ticks 7, 8, 9; bit value = majority of the three, evaluated at tick 9.
- START: value 1 -> false start, return to IDLE, no pulses; value 0 -> DATA.
- DATA: 8 bits, LSB first, shifted into an 8-bit register; after bit 7 go to PAR (if compiled in) else STOP.
- PAR: compare received bit with XOR of data (XOR with PARITY_ODD); store mismatch flag.
- STOP: value 1 and no parity mismatch -> push byte; value 1 with mismatch -> drop byte, pulse `parity_err_o`, IDLE; value 0 -> drop byte, pulse `frame_err_o`, go WAIT_HIGH (stop 0 overrides parity error; only `frame_err_o` pulses).
- WAIT_HIGH: stay until synchronised line is 1 (break handling), then IDLE.
- From STOP with value 1, the FSM returns to IDLE at tick 9, so a following start edge arriving in the second half of the stop bit is caught.
- FIFO: pointers one bit wider than log2(FIFO_DEPTH), wrap naturally. Push when full -> byte discarded, `overrun_o` pulses, contents unchanged. Push and pop in the same cycle when full -> both performed, no overrun. Pop when empty ignored.
- Reset (any time, including mid-frame): FSM IDLE, FIFO empty, counters 0, all outputs 0 (`rdata_o` = 8'h00), synchroniser = 1; in-flight byte lost.

## Timing
- Synchroniser latency: 2 clocks.
- Push occurs on the clock edge after the tick-9 evaluation of the stop bit; `rvalid_o` and `rdata_o` update on that same edge (registered FIFO status), i.e. ≤ 3 clocks after the stop-bit vote.
- Error and overrun pulses are registered, exactly one clock wide, asserted in the cycle the drop decision is made.
- `rdata_o` changes to the next entry the clock after a pop; `rvalid_o` falls the clock after popping the last entry.
- `busy_o` rises 1 clock after the synchronised start edge, falls when IDLE is re-entered.

## Configuration
- `UART_RX_PARITY_EN` defined: frame = start + 8 data + parity + stop; PAR state and `parity_err_o` active, PARITY_ODD honoured.
- Not defined: frame = start + 8 data + stop; PAR state absent, `parity_err_o` tied 0, PARITY_ODD ignored.

## Test plan
- BAUD_DIV=4, send 8'hA5 at exactly 64 clk/bit, `rready_i`=0 -> `rvalid_o`=1, `rdata_o`=8'hA5, no error pulses.
- Low glitch of 20 clocks on idle line -> no push, no pulses, `busy_o` returns to 0 within ~40 clocks.
- Send 8'h3C with stop bit driven 0 then line held low 200 clocks -> one `frame_err_o` pulse, FIFO stays empty; next valid 8'h11 received correctly after line returns high.
- FIFO_DEPTH=4, send 5 bytes 8'h01..8'h05 with `rready_i`=0 -> one `overrun_o` pulse on byte 5; popping yields 01,02,03,04 then `rvalid_o`=0.
- With `UART_RX_PARITY_EN`, PARITY_ODD=0, send 8'h07 with parity bit 0 -> `parity_err_o` pulse, no push; with parity bit 1 -> 8'h07 pushed.
- Assert `arst_n_i` low mid-data-bit of a frame, release, send 8'h5A -> FIFO contains only 8'h5A, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with FWFT receive FIFO.
// Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx_os #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       rx_i,
  output logic [7:0] rdata_o,
  output logic       rvalid_o,
  input  logic       rready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HIGH
  } state_e;

  state_e      state_q, state_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic [15:0] tick_q, tick_d;
  logic [3:0]  samp_q, samp_d;
  logic        v7_q, v7_d;
  logic        v8_q, v8_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shr_q, shr_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        rvalid_q, rvalid_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic tick, fall, start, eval, maj;
  logic push, full, pop, wr;

`ifdef UART_RX_PARITY_EN
  localparam logic PODD = (PARITY_ODD != 0);
  logic par_err_q, par_err_d;
  logic parity_err_q, par_fail;
`else
  logic unused_par;
  assign unused_par = (PARITY_ODD != 0);
`endif

  assign tick  = (tick_q == 16'(BAUD_DIV - 1));
  assign fall  = rx_s3_q & ~rx_s2_q;
  assign start = (state_q == IDLE) & fall;
  assign eval  = tick & (samp_q == 4'd9);
  assign maj   = (v7_q & v8_q)
               | (v7_q & rx_s2_q)
               | (v8_q & rx_s2_q);

  always_comb begin
    tick_d = tick ? 16'd0 : tick_q + 16'd1;
    samp_d = tick ? samp_q + 4'd1 : samp_q;
    v7_d   = v7_q;
    v8_d   = v8_q;
    if (tick && samp_q == 4'd7) v7_d = rx_s2_q;
    if (tick && samp_q == 4'd8) v8_d = rx_s2_q;
    if (start) begin
      tick_d = 16'd0;
      samp_d = 4'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shr_d    = shr_q;
    push     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    par_fail  = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (fall) state_d = START;
      START: if (eval) begin
        bit_d   = 3'd0;
        state_d = maj ? IDLE : DATA;
      end
      DATA: if (eval) begin
        shr_d = {maj, shr_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: if (eval) begin
        par_err_d = maj ^ (^shr_q) ^ PODD;
        state_d   = STOP;
      end
`endif
      STOP: if (eval) begin
        state_d = IDLE;
        // A low stop bit wins over a parity mismatch
        if (!maj) begin
          frame_err_d = 1'b1;
          state_d     = WAIT_HIGH;
        end
`ifdef UART_RX_PARITY_EN
        else if (par_err_q) par_fail = 1'b1;
`endif
        else push = 1'b1;
      end
      WAIT_HIGH: if (rx_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign full = (wptr_q[AW] != rptr_q[AW])
              && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop  = rvalid_q & rready_i;
  assign wr   = push & (~full | pop);

  always_comb begin
    wptr_d    = wptr_q + {{AW{1'b0}}, wr};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    rvalid_d  = (wptr_d != rptr_d);
    overrun_d = push & full & ~pop;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      state_q     <= IDLE;
      tick_q      <= 16'd0;
      samp_q      <= 4'd0;
      v7_q        <= 1'b1;
      v8_q        <= 1'b1;
      bit_q       <= 3'd0;
      shr_q       <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      rx_s1_q     <= rx_i;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      samp_q      <= samp_d;
      v7_q        <= v7_d;
      v8_q        <= v8_d;
      bit_q       <= bit_d;
      shr_q       <= shr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rvalid_q    <= rvalid_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_err_q    <= par_err_d;
      parity_err_q <= par_fail;
    end
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Storage needs no reset; rvalid gates the head output
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= shr_q;
  end

  assign rdata_o     = rvalid_q ? mem_q[rptr_q[AW-1:0]] : 8'h00;
  assign rvalid_o    = rvalid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: randomized scoreboard bench for uart_rx_os.
// Frame format follows UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int   BD     = 4;
  localparam int   DEPTH  = 4;
  localparam int   BIT    = 16 * BD;
  localparam logic PODD   = 1'b0;
  localparam int   EV_FRM = 1;
  localparam int   EV_PAR = 2;
  localparam int   EV_OVR = 3;

  logic       clk_i = 1'b0;
  logic       arst_n_i;
  logic       rx_i;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic       rready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_data[$];
  int         exp_evt[$];

  always #5 clk_i = ~clk_i;

  uart_rx_os #(
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(DEPTH),
    .PARITY_ODD(0)
  ) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .rx_i        (rx_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h",
               name, act, exp);
    end
  endtask

  task automatic see_evt(input int k);
    int e;
    if (exp_evt.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL pulse_unexpected: got kind %0d, required none", k);
    end else begin
      e = exp_evt.pop_front();
      chk("pulse_kind", k, e);
    end
  endtask

  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (rvalid_o && rready_i) begin
        if (exp_data.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rdata_unexpected: got %0h, required no data",
                   rdata_o);
        end else begin
          chk("rdata_pop", rdata_o, exp_data.pop_front());
        end
      end
      if (frame_err_o)  see_evt(EV_FRM);
      if (parity_err_o) see_evt(EV_PAR);
      if (overrun_o)    see_evt(EV_OVR);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rvalid"}, rvalid_o, 0);
    chk({name, "_rdata"}, rdata_o, 0);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_errs"},
        {frame_err_o, parity_err_o, overrun_o}, 0);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pb,
                            input logic sv);
    rx_i = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      tick(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = (^d) ^ PODD ^ pb;
    tick(BIT);
`endif
    if (!sv) exp_evt.push_back(EV_FRM);
    else if (pb) exp_evt.push_back(EV_PAR);
    else if (exp_data.size() >= DEPTH) exp_evt.push_back(EV_OVR);
    else exp_data.push_back(d);
    rx_i = sv;
    tick(BIT);
    chk("pulse_missing", exp_evt.size(), 0);
    chk("rvalid_after_frame", rvalid_o, exp_data.size() != 0);
    if (exp_data.size() != 0)
      chk("rdata_head", rdata_o, exp_data[0]);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_data.size() != 0; i++) begin
      rready_i = 1'($urandom_range(0, 1));
      tick(1);
    end
    rready_i = 1'b0;
    chk("drain_all_seen", exp_data.size(), 0);
    tick(2);
    chk("drain_rvalid_low", rvalid_o, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pb;
    logic       sv;
    rx_i     = 1'b1;
    rready_i = 1'b0;
    arst_n_i = 1'b0;
    tick(3);
    chk_zero("reset");
    arst_n_i = 1'b1;
    tick(BIT);

    send_frame(8'hA5, 1'b0, 1'b1);
    drain();

    rx_i = 1'b0;
    tick(10);
    chk("glitch_busy_hi", busy_o, 1);
    tick(10);
    rx_i = 1'b1;
    tick(60);
    chk("glitch_busy_lo", busy_o, 0);
    chk("glitch_no_push", rvalid_o, 0);

    send_frame(8'h3C, 1'b0, 1'b0);
    tick(200);
    rx_i = 1'b1;
    tick(BIT);
    chk("ferr_fifo_empty", rvalid_o, 0);
    send_frame(8'h11, 1'b0, 1'b1);
    drain();

    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b0, 1'b1);
      tick(8);
    end
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    tick(8);
    send_frame(8'h07, 1'b0, 1'b1);
    drain();
`endif

    d = 8'hC3;
    rx_i = 1'b0;
    tick(BIT);
    for (int i = 0; i < 3; i++) begin
      rx_i = d[i];
      tick(BIT);
    end
    rx_i = d[3];
    tick(BIT / 2);
    chk("busy_mid_frame", busy_o, 1);
    arst_n_i = 1'b0;
    tick(2);
    chk_zero("reset_mid");
    rx_i = 1'b1;
    tick(4);
    exp_data.delete();
    exp_evt.delete();
    arst_n_i = 1'b1;
    tick(BIT);
    send_frame(8'h5A, 1'b0, 1'b1);
    drain();

    for (int f = 0; f < 40; f++) begin
      d  = 8'($urandom);
      sv = ($urandom_range(0, 7) != 0);
      pb = 1'b0;
`ifdef UART_RX_PARITY_EN
      pb = ($urandom_range(0, 7) == 0);
`endif
      send_frame(d, pb, sv);
      if (!sv) begin
        tick(int'($urandom_range(0, 100)));
        rx_i = 1'b1;
        tick(4);
      end
      tick(int'($urandom_range(1, 30)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    tick(50);
    chk("events_left", exp_evt.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
